mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Data-memory access stage that sits directly downstream of the load/store controller.
- Accepts one load or store request at a time (address, store data, funct3) and checks alignment and funct3.
- Drives a single-port, word-addressed, byte-enabled data memory with a variable-latency ready handshake.
- Returns sign/zero-extended load data or a store completion with a fault flag. `busy` stalls the core while an access is in flight.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr; the memory word address is ADDR_WIDTH-2 bits.
- TIMEOUT, 16, maximum WAIT cycles before a fault is reported; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  ADDR_WIDTH  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  qualifies rsp_valid: misaligned, illegal funct3, or timeout.
- busy  out  1  access in flight (state != IDLE).
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte write enables (0 for loads).
- mem_addr  out  ADDR_WIDTH-2  word address = req_addr[ADDR_WIDTH-1:2].
- mem_wdata  out  32  lane-aligned store data.
- mem_rdata  in  32  memory read word.
- mem_ready  in  1  memory has completed the access.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; the timeout counter and all registered outputs clear to 0.
  - req_ready=0 while rst_n=0, and 1 in IDLE afterwards.
  - Reset mid-access abandons the access; no rsp_valid is produced for it.
- Accepted request: a request is accepted when req_valid & req_ready in IDLE. The unit latches we, funct3, addr, wdata and addr[1:0].
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- States:
  - IDLE: req_ready=1, all outputs 0.
    - Illegal or misaligned request -> RESP with fault=1. No memory strobe is issued.
    - Otherwise -> ACCESS.
  - ACCESS (exactly 1 cycle): mem_en=1, with mem_addr/mem_we/mem_wdata held from the latched request. Always -> WAIT. mem_ready is ignored in this state.
  - WAIT: mem_en=0. The counter increments each cycle.
    - mem_ready=1 -> RESP. For loads, mem_rdata is captured in the same edge.
    - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1 -> RESP with fault=1.
    - mem_ready takes priority over timeout in the same cycle.
  - RESP (1 cycle): rsp_valid=1 with rsp_rdata/rsp_fault. Always -> IDLE. A new request can be accepted in the following cycle.
- Minimum latency: accept at cycle 0, mem_en at cycle 1, mem_ready at cycle 2, rsp_valid at cycle 3.
- Store lanes, with o=addr[1:0]:
  - SB: mem_we=4'b0001<<o, mem_wdata={4{wdata[7:0]}}.
  - SH: mem_we=4'b0011<<{o[1],1'b0}, mem_wdata={2{wdata[15:0]}}.
  - SW: mem_we=4'b1111, mem_wdata=wdata.
- Load extraction from the captured word:
  - Byte = word[8*o+7:8*o].
  - Half = word[16*o[1]+15:16*o[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Outputs are zero outside their active state: rsp_* are 0 outside RESP; mem_* are 0 outside ACCESS.

Test Plan:
- LW at addr 0x100: mem_rdata=0xDEADBEEF with mem_ready at cycle 2 -> mem_en=1, mem_addr=0x40, mem_we=0 at cycle 1; rsp_valid at cycle 3 with rsp_rdata=0xDEADBEEF, rsp_fault=0; busy high during cycles 1-3.
- LB/LBU/LH/LHU at addr 0x103/0x102 with mem_rdata=0x80FF7F01:
  - LB @0x103 -> 0xFFFFFF80.
  - LBU @0x103 -> 0x00000080.
  - LH @0x102 -> 0xFFFF80FF.
  - LHU @0x102 -> 0x000080FF.
- SB 0xAB at 0x201 -> mem_we=0010, mem_wdata=0xABABABAB. SH 0x1234 at 0x202 -> mem_we=1100, mem_wdata=0x12341234. Both give rsp_valid with rsp_rdata=0.
- LW at 0x102, and funct3=011 -> no mem_en; rsp_valid with rsp_fault=1 one cycle after accept.
- mem_ready held low with TIMEOUT=4 -> rsp_fault=1 after 4 WAIT cycles. A separate run with mem_ready rising on the 4th WAIT cycle -> no fault.
- rst_n=0 during WAIT -> next cycle all outputs 0, state IDLE, no rsp_valid. After release, req_ready=1 and a new LW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage downstream of the load/store
// controller. It accepts one load/store request at a time and checks funct3
// and alignment. It then drives a single-port, word-addressed, byte-enabled
// memory that answers through a variable-latency ready handshake, and
// returns extended load data or a store completion with a fault flag.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   req_valid/req_ready   request handshake; accepted in IDLE only
//   req_we, req_funct3    store/load select and RV32I width/sign code
//   req_addr, req_wdata   byte address and store data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_fault  extended load data (0 for stores/faults), fault flag
//   busy                  access in flight (state != IDLE)
//   mem_en, mem_we        memory strobe and byte write enables (ACCESS only)
//   mem_addr, mem_wdata   word address and lane-aligned store data
//   mem_rdata, mem_ready  memory read word and completion
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic                  busy,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // One spare bit so TIMEOUT-1 always fits, including TIMEOUT=0/1.
  localparam int CW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [31:0]           rdata_q;
  logic                  fault_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // f3[1:0] encodes the access width for every legal code.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] o);
    return ((f3[1:0] == 2'b01) && o[0]) || ((f3[1:0] == 2'b10) && (o != 2'b00));
  endfunction

  function automatic logic [3:0] store_we(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   return 4'b0001 << o;
      2'b01:   return 4'b0011 << {o[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] o,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {o, 3'b000});
    h = 16'(w >> {o[1], 4'b0000});
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Request fields are only consumed after acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            if (!f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0])) begin
              state   <= S_RESP;
              fault_q <= 1'b1;
              rdata_q <= '0;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: state <= S_WAIT;
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // Ready wins over a timeout expiring in the same cycle.
          if (mem_ready) begin
            state   <= S_RESP;
            fault_q <= 1'b0;
            rdata_q <= we_q ? 32'h0 : load_extend(funct3_q, addr_q[1:0], mem_rdata);
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            state   <= S_RESP;
            fault_q <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: begin
          state   <= S_IDLE;
          fault_q <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready = rst_n && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_fault = rsp_valid & fault_q;
  assign mem_en    = (state == S_ACCESS);
  assign mem_addr  = mem_en ? addr_q[ADDR_WIDTH-1:2] : '0;
  assign mem_we    = (mem_en && we_q) ? store_we(funct3_q, addr_q[1:0]) : 4'b0000;
  assign mem_wdata = (mem_en && we_q) ? store_data(funct3_q, wdata_q) : 32'h0;

endmodule
